// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch controller: instruction type and FSM state codes.
package branch_ctrl_pkg;

  localparam logic [1:0] B_TYPE    = 2'b10;
  localparam logic [0:0] BRC_RUN   = 1'b0;
  localparam logic [0:0] BRC_FLUSH = 1'b1;

  // Branch targets must land on a 32-bit instruction word.
  function automatic logic f_word_aligned(input logic [31:0] addr);
    f_word_aligned = (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/branch_ctrl_flush_counter.sv
// Down-counter that times the flush window after a redirect.
module branch_ctrl_flush_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and PC sequencing: samples the CCR branch flag, owns the PC,
// and issues a one-cycle redirect followed by a fixed-length flush.
module branch_ctrl #(
  parameter int          FLUSH_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       type_in,
  input  logic             br_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      imm_in,
  input  logic             stall_in,
  output logic [31:0]      pc_out,
  output logic             redirect_out,
  output logic             flush_out,
  output logic             fault_out,
  output logic [CNT_W-1:0] taken_cnt
);
  import branch_ctrl_pkg::*;

  localparam int FW = $clog2(FLUSH_DEPTH + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_DEPTH - 1);

  logic [0:0]       r_state;
  logic [31:0]      r_pc;
  logic             r_redirect;
  logic             r_flush;
  logic             r_fault;
  logic [CNT_W-1:0] r_taken_cnt;

  logic        w_accept;
  logic        w_take;
  logic        w_zero;
  logic [31:0] w_target;

  assign w_target = pc_in + imm_in;
  assign w_accept = (r_state == BRC_RUN) && valid_in && (type_in == B_TYPE) && br_in && !stall_in;
  assign w_take   = w_accept && f_word_aligned(w_target);

  branch_ctrl_flush_counter #(.W(FW)) u_flush_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_take),
    .i_load_val (FLUSH_LOAD),
    .i_dec      (r_state == BRC_FLUSH),
    .o_zero     (w_zero)
  );

  // PC sequencing, redirect/fault pulses and flush window state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BRC_RUN;
      r_pc        <= RESET_PC;
      r_redirect  <= 1'b0;
      r_flush     <= 1'b0;
      r_fault     <= 1'b0;
      r_taken_cnt <= {CNT_W{1'b0}};
    end else begin
      r_redirect <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        BRC_RUN: begin
          if (w_take) begin
            r_pc       <= w_target;
            r_redirect <= 1'b1;
            r_flush    <= 1'b1;
            r_state    <= BRC_FLUSH;
            if (r_taken_cnt != {CNT_W{1'b1}}) begin
              r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              r_taken_cnt <= r_taken_cnt;
            end
          end else if (!stall_in) begin
            // A misaligned target only raises fault; sequencing continues as not-taken.
            r_pc    <= r_pc + 32'd4;
            r_fault <= w_accept;
            r_flush <= 1'b0;
          end else begin
            r_pc    <= r_pc;
            r_flush <= 1'b0;
          end
        end
        BRC_FLUSH: begin
          if (w_zero) begin
            r_state <= BRC_RUN;
            r_flush <= 1'b0;
          end else begin
            r_flush <= 1'b1;
          end
        end
        default: begin
          r_state <= BRC_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out       = r_pc;
  assign redirect_out = r_redirect;
  assign flush_out    = r_flush;
  assign fault_out    = r_fault;
  assign taken_cnt    = r_taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed vectors push expected outputs, a monitor checks them.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        red;
    logic        fl;
    logic        fa;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  type_in = 2'b00;
  logic        br_in = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] imm_in = 32'h0;
  logic        stall_in = 1'b0;
  logic [31:0] pc_out;
  logic        redirect_out, flush_out, fault_out;
  logic [15:0] taken_cnt;

  logic [31:0] s_pc_out;
  logic        s_redirect, s_flush, s_fault;
  logic [3:0]  s_cnt;
  logic        s_valid = 1'b1;
  logic        s_br = 1'b1;
  logic        s_stall = 1'b0;
  logic [1:0]  s_type = B_TYPE;
  logic [31:0] s_zero32 = 32'h0;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_DEPTH(2), .RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .type_in(type_in), .br_in(br_in),
    .pc_in(pc_in), .imm_in(imm_in), .stall_in(stall_in), .pc_out(pc_out),
    .redirect_out(redirect_out), .flush_out(flush_out), .fault_out(fault_out),
    .taken_cnt(taken_cnt)
  );

  // Small-counter instance branching continuously to exercise saturation and FLUSH_DEPTH=1.
  branch_ctrl #(.FLUSH_DEPTH(1), .RESET_PC(32'h0000_0000), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .valid_in(s_valid), .type_in(s_type), .br_in(s_br),
    .pc_in(s_zero32), .imm_in(s_zero32), .stall_in(s_stall), .pc_out(s_pc_out),
    .redirect_out(s_redirect), .flush_out(s_flush), .fault_out(s_fault),
    .taken_cnt(s_cnt)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] t, input logic b, input logic [31:0] p,
                      input logic [31:0] im, input logic s, input logic [31:0] epc,
                      input logic ered, input logic efl, input logic efa, input logic [15:0] ecnt);
    exp_t e;
    valid_in = v; type_in = t; br_in = b; pc_in = p; imm_in = im; stall_in = s;
    n_step++;
    e.idx = n_step; e.pc = epc; e.red = ered; e.fl = efl; e.fa = efa; e.cnt = ecnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] epc, input logic efl, input logic [15:0] ecnt);
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, epc, 1'b0, efl, 1'b0, ecnt);
  endtask

  // Monitor: every clock the DUT presents a new registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out",    e.idx, pc_out,                 e.pc);
        chk("redirect",  e.idx, {31'd0, redirect_out},  {31'd0, e.red});
        chk("flush",     e.idx, {31'd0, flush_out},     {31'd0, e.fl});
        chk("fault",     e.idx, {31'd0, fault_out},     {31'd0, e.fa});
        chk("taken_cnt", e.idx, {16'd0, taken_cnt},     {16'd0, e.cnt});
      end
    end
  end

  initial begin
    #2;
    chk("rst_pc",    0, pc_out, 32'h0);
    chk("rst_flags", 0, {29'd0, redirect_out, flush_out, fault_out}, 32'h0);
    chk("rst_cnt",   0, {16'd0, taken_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    idle(32'h4, 1'b0, 16'd0);
    idle(32'h8, 1'b0, 16'd0);
    idle(32'hC, 1'b0, 16'd0);
    // Aligned taken branch, two-cycle flush, then resume +4.
    step(1'b1, B_TYPE, 1'b1, 32'h100, 32'h40, 1'b0, 32'h140, 1'b1, 1'b1, 1'b0, 16'd1);
    idle(32'h140, 1'b1, 16'd1);
    idle(32'h140, 1'b0, 16'd1);
    idle(32'h144, 1'b0, 16'd1);
    // Misaligned target: fault only.
    step(1'b1, B_TYPE, 1'b1, 32'h100, 32'h2, 1'b0, 32'h148, 1'b0, 1'b0, 1'b1, 16'd1);
    idle(32'h14C, 1'b0, 16'd1);
    // Stall beats branch, then the held branch is taken.
    step(1'b1, B_TYPE, 1'b1, 32'h200, 32'h10, 1'b1, 32'h14C, 1'b0, 1'b0, 1'b0, 16'd1);
    step(1'b1, B_TYPE, 1'b1, 32'h200, 32'h10, 1'b0, 32'h210, 1'b1, 1'b1, 1'b0, 16'd2);
    step(1'b1, B_TYPE, 1'b1, 32'h300, 32'h100, 1'b0, 32'h210, 1'b0, 1'b1, 1'b0, 16'd2);
    idle(32'h210, 1'b0, 16'd2);
    idle(32'h214, 1'b0, 16'd2);
    // Wrapping target; a branch during FLUSH is ignored.
    step(1'b1, B_TYPE, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 16'd3);
    step(1'b1, B_TYPE, 1'b1, 32'h0, 32'h80, 1'b0, 32'h10, 1'b0, 1'b1, 1'b0, 16'd3);
    idle(32'h10, 1'b0, 16'd3);
    // Non-branch type with br_in set is ignored.
    step(1'b1, 2'b00, 1'b1, 32'h400, 32'h40, 1'b0, 32'h14, 1'b0, 1'b0, 1'b0, 16'd3);
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 16'd3);
    // Negative offset; stall does not extend the flush window.
    step(1'b1, B_TYPE, 1'b1, 32'h100, 32'hFFFF_FFF0, 1'b0, 32'hF0, 1'b1, 1'b1, 1'b0, 16'd4);
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'hF0, 1'b0, 1'b1, 1'b0, 16'd4);
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'hF0, 1'b0, 1'b0, 1'b0, 16'd4);
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'hF0, 1'b0, 1'b0, 1'b0, 16'd4);
    idle(32'hF4, 1'b0, 16'd4);
    step(1'b1, B_TYPE, 1'b1, 32'h0, 32'h1000, 1'b0, 32'h1000, 1'b1, 1'b1, 1'b0, 16'd5);
    valid_in = 1'b0; br_in = 1'b0; type_in = 2'b00;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain", n_step, q.size(), 32'd0);

    // Asynchronous reset in the middle of FLUSH.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc",    n_step, pc_out, 32'h0);
    chk("arst_flush", n_step, {31'd0, flush_out}, 32'h0);
    chk("arst_cnt",   n_step, {16'd0, taken_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) idle(32'(i * 4), 1'b0, 16'd0);
    chk("sat_cnt", n_step, {28'd0, s_cnt}, 32'hF);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain_end", n_step, q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
